// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed 4-digit, 7-segment display scanner.
// A loaded value is committed to the display only while idle or on a frame
// boundary, so a frame never shows a mix of two values.
//
// load/load_ack: load is a one-cycle strobe that captures din into a pending
// register. It is never back-pressured, and a later load overwrites an
// uncommitted one. load_ack pulses for one cycle after each commit of the
// pending value to the display. pending stays high from the cycle after a load
// until the commit.
module seg_scan_ctrl #(
  parameter int PRESCALE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] din,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  hex0,
  output logic        pending,
  output logic        load_ack
);

  localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [15:0]     disp_q, disp_d;
  logic [15:0]     pend_val_q, pend_val_d;
  logic            pend_q, pend_d;
  logic            ack_q, ack_d;

  logic            frame_end;
  logic            commit;

  // Active-low glyphs, bit 6 = segment a ... bit 0 = segment g.
  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'h0: g = 7'b0000001;
      4'h1: g = 7'b1001111;
      4'h2: g = 7'b0010010;
      4'h3: g = 7'b0000110;
      4'h4: g = 7'b1001100;
      4'h5: g = 7'b0100100;
      4'h6: g = 7'b0100000;
      4'h7: g = 7'b0001111;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0000100;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b1100000;
      4'hC: g = 7'b0110001;
      4'hD: g = 7'b1000010;
      4'hE: g = 7'b0110000;
      default: g = 7'b0111000;
    endcase
    return g;
  endfunction

  // State register; reset wins over load and en on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      disp_q     <= '0;
      pend_val_q <= '0;
      pend_q     <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      disp_q     <= disp_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
      ack_q      <= ack_d;
    end
  end

  // Next-state: scan timing, commit at idle or frame end, pending capture.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    disp_d     = disp_q;
    pend_val_d = pend_val_q;
    pend_d     = pend_q;
    ack_d      = 1'b0;

    frame_end = (state_q == SCAN) && (cnt_q == CNT_MAX) && (idx_q == 2'd3);
    commit    = pend_q && ((state_q == IDLE) || frame_end);

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (en) state_d = SCAN;
      end
      SCAN: begin
        if (!en) begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          cnt_d = '0;
          idx_d = idx_q + 2'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Commit uses the old pending value; a same-cycle load re-arms pending.
    if (commit) begin
      disp_d = pend_val_q;
      pend_d = 1'b0;
      ack_d  = 1'b1;
    end
    if (load) begin
      pend_val_d = din;
      pend_d     = 1'b1;
    end
  end

  // Output decode straight from registered state, with leading-zero blanking.
  always_comb begin
    logic [3:0] dig;
    logic       lz;
    an   = 4'b1111;
    hex0 = 7'b1111111;
    dig  = 4'h0;
    lz   = 1'b0;
    case (idx_q)
      2'd0: begin dig = disp_q[3:0];   lz = 1'b0;                   end
      2'd1: begin dig = disp_q[7:4];   lz = (disp_q[15:4]  == '0);  end
      2'd2: begin dig = disp_q[11:8];  lz = (disp_q[15:8]  == '0);  end
      default: begin dig = disp_q[15:12]; lz = (disp_q[15:12] == '0); end
    endcase
    if ((state_q == SCAN) && !(blank_lz && lz)) begin
      an        = 4'b1111;
      an[idx_q] = 1'b0;
      hex0      = glyph(dig);
    end
  end

  assign pending  = pend_q;
  assign load_ack = ack_q;

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter: PRESCALE, 4, clock cycles per digit slot (integer >= 2).
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: en  input  1  1 = scan display; 0 = blank display.
REQ-005 Port: load  input  1  single-cycle strobe; captures din as the new display value.
REQ-006 Port: din  input  16  four hex digits; digit k = din[4k+3:4k], digit 0 rightmost.
REQ-007 Port: blank_lz  input  1  1 = blank leading zero digits.
REQ-008 Port: an  output  4  digit enables, active-low, at most one bit low.
REQ-009 Port: hex0  output  7  segments, active-low, hex0[6]=a ... hex0[0]=g.
REQ-010 Port: pending  output  1  a loaded value is waiting to be committed.
REQ-011 Port: load_ack  output  1  one-cycle pulse: the pending value was committed to the display.

Function
REQ-012 State registers: state {IDLE, SCAN}, cnt (0..PRESCALE-1), idx (0..3), disp_q[15:0], pend_val[15:0], pend_q, ack_q.
REQ-013 IDLE -> SCAN on the edge where en=1; SCAN -> IDLE on the edge where en=0. Entering IDLE sets cnt=0 and idx=0.
REQ-014 In SCAN, cnt increments every cycle. At cnt=PRESCALE-1, cnt wraps to 0 and idx advances 0->1->2->3->0.
REQ-015 Frame boundary: a SCAN cycle with cnt=PRESCALE-1 and idx=3.
REQ-016 an and hex0 are a combinational decode of registered state, with no extra lag. In IDLE: an=4'b1111 and hex0=7'b1111111.
REQ-017 In SCAN: an[idx]=0 and all other an bits are 1. hex0 = glyph(disp_q digit idx).
REQ-018 Glyphs, active-low, a..g:
  0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111,
  8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
REQ-019 Leading-zero blanking: when blank_lz=1, digit k>0 is blanked if digits k..3 of disp_q are all zero. A blanked slot drives an=4'b1111 and hex0=7'b1111111 but still occupies its PRESCALE cycles. Digit 0 is never blanked.
REQ-020 On load=1: pend_val<=din and pend_q<=1. pending = pend_q.
REQ-021 Commit: pend_q=1 and (state=IDLE, or a frame-boundary cycle). The commit cycle sets disp_q<=pend_val and pend_q<=0. load_ack=1 on the following cycle only.
REQ-022 load on a commit cycle: the old pend_val is committed, then din is stored and pend_q stays 1. Exactly one load_ack is produced for that commit.
REQ-023 Multiple loads before a commit: the last din wins, and only one load_ack is produced.
REQ-024 disp_q never changes mid-frame while in SCAN; there is no tearing.
REQ-025 en and blank_lz changes take effect on the next edge and the same cycle respectively, with no effect on pending, pend_val or disp_q.

Reset
REQ-026 While rst=1:
  - state=IDLE, cnt=0, idx=0
  - disp_q=0, pend_val=0, pend_q=0, ack_q=0
  - outputs: an=4'b1111, hex0=7'b1111111, pending=0, load_ack=0
REQ-027 rst overrides load and en on the same edge. A pending value is discarded on reset mid-operation.

Verification (PRESCALE=4)
REQ-028 Reset: rst=1 for 2 cycles with en=1 and load=1 -> an=1111, hex0=1111111, pending=0, load_ack=0 during and after the reset cycle.
REQ-029 Idle commit and scan:
  - Stimulus: en=0, load din=16'h12AF, then en=1.
  - Commit and ack: commit on the next edge, load_ack=1 for one cycle.
  - Scan output: an=1110/hex0=0111000 (F) for 4 cycles, then 1101/0001000 (A), then 1011/0010010 (2), then 0111/1001111 (1), then repeat.
REQ-030 Mid-frame load:
  - Stimulus: while scanning 16'h12AF, load din=16'h0008 at idx=1.
  - pending=1 and the display stays 12AF until the frame boundary.
  - Next slot shows idx 0 = 0000000 (8), and load_ack pulses once, 1 cycle after the boundary.
REQ-031 Leading-zero blanking:
  - disp_q=16'h0030 with blank_lz=1 -> slots 3 and 2 show an=1111/hex0=1111111, slot 1 shows 0000110 (3), slot 0 shows 0000001 (0).
  - disp_q=16'h0000 with blank_lz=1 -> only slot 0 is lit, showing 0.
REQ-032 en drop: en=0 at idx=2, cnt=1 -> next cycle an=1111 and idx=0. With en=1 again, digit 0 is shown for a full 4 cycles first.
REQ-033 Reset mid-scan: rst=1 with pending=1 -> pending=0, no load_ack, disp_q=0. After rst is released with en=1, all four slots show 0000001 when blank_lz=0.
